// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling NUM_CH requesters onto one memory port.
// Only one transaction is in flight at a time. Faults are answered without touching memory.
module mem_arbiter #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH-1:0]          req_we,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_exc_valid,
    output logic [3:0]                 rsp_exc_code,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_W-1:0]          mem_rsp_data
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [CH_W-1:0]     last_grant, grant, cur_ch;
    logic                any_req;
    int unsigned         idx;
    logic [ADDR_W-1:0]   sel_addr, cur_addr;
    logic [DATA_W-1:0]   sel_wdata, cur_wdata, rsp_data_r;
    logic                sel_we, cur_we;
    logic                misaligned, out_of_range, accept_exc;
    logic [3:0]          accept_code, code_r;
    logic                exc_r;
    logic [CNT_W-1:0]    cnt;
    logic                timed_out;

    function automatic logic [3:0] fault_code(input logic misal, input logic we, input logic fetch);
        if (misal) return we ? 4'd6 : (fetch ? 4'd0 : 4'd4);
        return we ? 4'd7 : (fetch ? 4'd1 : 4'd5);
    endfunction

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        grant   = last_grant;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = 32'(last_grant) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!any_req && req_valid[CH_W'(idx)]) begin
                any_req = 1'b1;
                grant   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        sel_addr     = req_addr[grant*ADDR_W +: ADDR_W];
        sel_wdata    = req_wdata[grant*DATA_W +: DATA_W];
        sel_we       = req_we[grant];
        misaligned   = sel_addr[1:0] != 2'b00;
        out_of_range = 64'(sel_addr) >= 64'(MEM_BYTES);
        accept_exc   = misaligned || out_of_range;
        accept_code  = accept_exc ? fault_code(misaligned, sel_we, grant == '0) : 4'd0;
    end

    assign timed_out = cnt >= CNT_W'(TIMEOUT - 1);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (any_req && RESET) begin
                    req_ready[grant] = 1'b1;
                    state_nxt = accept_exc ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (timed_out)          state_nxt = RESP;
                else if (mem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                // A response landing on the final cycle still counts as completion.
                if (mem_rsp_valid || timed_out) state_nxt = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            last_grant <= CH_W'(NUM_CH - 1);
            cnt        <= '0;
            cur_ch     <= '0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            cur_we     <= 1'b0;
            exc_r      <= 1'b0;
            code_r     <= '0;
            rsp_data_r <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_ch     <= grant;
                        cur_addr   <= sel_addr;
                        cur_wdata  <= sel_wdata;
                        cur_we     <= sel_we;
                        last_grant <= grant;
                        cnt        <= '0;
                        exc_r      <= accept_exc;
                        code_r     <= accept_code;
                        rsp_data_r <= '0;
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (timed_out) begin
                        exc_r  <= 1'b1;
                        code_r <= fault_code(1'b0, cur_we, cur_ch == '0);
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rsp_valid) begin
                        rsp_data_r <= cur_we ? '0 : mem_rsp_data;
                    end else if (timed_out) begin
                        exc_r  <= 1'b1;
                        code_r <= fault_code(1'b0, cur_we, cur_ch == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_valid = state == ISSUE;
    assign mem_we        = mem_req_valid & cur_we;
    assign mem_addr      = mem_req_valid ? cur_addr  : '0;
    assign mem_wdata     = mem_req_valid ? cur_wdata : '0;

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) rsp_valid[cur_ch] = 1'b1;
    end

    assign rsp_exc_valid = (state == RESP) & exc_r;
    assign rsp_exc_code  = (state == RESP) ? code_r : '0;
    assign rsp_data      = (state == RESP && !exc_r) ? rsp_data_r : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expectations are queued when a request is driven
// and compared against each rsp_valid pulse, including latency from acceptance.
module tb_mem_arbiter;

    localparam int NCH = 3;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic [NCH-1:0]    req_valid = '0, req_ready, req_we = '0;
    logic [NCH*32-1:0] req_addr = '0, req_wdata = '0;
    logic [NCH-1:0]    rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_exc_valid;
    logic [3:0]        rsp_exc_code;
    logic              mem_req_valid, mem_req_ready, mem_we;
    logic [31:0]       mem_addr, mem_wdata;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;

    mem_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .MEM_BYTES(65536), .TIMEOUT(64)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_exc_valid(rsp_exc_valid), .rsp_exc_code(rsp_exc_code),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          ch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] data;
        logic        exc;
        logic [3:0]  code;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0, n_err = 0;
    int          cyc = 0, accept_cyc = 0, mreq_cycles = 0;
    logic        ready_en = 1'b1, inject = 1'b0, mreq_prev = 1'b0;
    logic [31:0] prev_addr = '0, pend_data = '0;
    int          rsp_delay = 1, pend = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return a * 32'd7 + 32'h1357;
    endfunction

    task automatic push(input int ch, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] data, input logic exc, input logic [3:0] code, input int lat);
        exp_t e;
        e.ch = ch; e.we = we; e.addr = addr; e.wd = wd;
        e.data = data; e.exc = exc; e.code = code; e.lat = lat;
        sb.push_back(e);
    endtask

    // Expected outcome for a request when memory answers after the given latency.
    task automatic expect_req(input int ch, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input int lat);
        if (addr[1:0] != 2'b00)
            push(ch, we, addr, wd, 0, 1'b1, we ? 4'd6 : (ch == 0 ? 4'd0 : 4'd4), 1);
        else if (addr >= 32'd65536)
            push(ch, we, addr, wd, 0, 1'b1, we ? 4'd7 : (ch == 0 ? 4'd1 : 4'd5), 1);
        else
            push(ch, we, addr, wd, we ? 32'h0 : mem_fn(addr), 1'b0, 4'd0, lat);
    endtask

    task automatic send(input int ch, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        @(negedge CLK);
        req_we[ch] = we;
        req_addr[ch*32 +: 32] = addr;
        req_wdata[ch*32 +: 32] = wd;
        req_valid[ch] = 1'b1;
        n = 0;
        #1;
        while (!req_ready[ch] && n < 300) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (!req_ready[ch]) check("accept_timeout", 0, 1);
        @(posedge CLK);
        #1;
        req_valid[ch] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge CLK);
    endtask

    // Memory model: stores return junk data that the DUT must replace with zero.
    initial begin
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        forever begin
            @(negedge CLK);
            mem_rsp_valid = inject;
            mem_rsp_data  = inject ? 32'hBAD0BAD0 : 32'h0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = pend_data;
                end
            end
            mem_req_ready = ready_en;
            if (mem_req_valid && ready_en) begin
                pend      = rsp_delay;
                pend_data = mem_we ? 32'h0BADF00D : mem_fn(mem_addr);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (RESET) begin
                if ((req_valid & req_ready) != 0) begin
                    accept_cyc = cyc;
                    if (sb.size() > 0) check("grant", req_valid & req_ready, 64'(1) << sb[0].ch);
                end
                if (mem_req_valid) begin
                    mreq_cycles++;
                    if (mreq_prev && mem_addr !== prev_addr) check("mem_addr_stable", mem_addr, prev_addr);
                    if (mem_req_ready && sb.size() > 0) begin
                        check("mem_addr", mem_addr, sb[0].addr);
                        check("mem_we", mem_we, sb[0].we);
                        if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wd);
                    end
                end
                mreq_prev = mem_req_valid;
                prev_addr = mem_addr;
                if (rsp_valid != 0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_ch", rsp_valid, 64'(1) << e.ch);
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_exc_valid", rsp_exc_valid, e.exc);
                        check("rsp_exc_code", rsp_exc_code, e.code);
                        check("latency", cyc - accept_cyc, e.lat);
                    end
                end
            end else begin
                mreq_prev = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, sb=%0d", sb.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '1;
        req_addr  = {32'h208, 32'h204, 32'h200};
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_exc_valid", rsp_exc_valid, 0);
        check("rst_exc_code", rsp_exc_code, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        req_valid = '0;
        req_addr  = '0;
        @(negedge CLK);
        #3 RESET = 1'b1;

        // Round robin with all channels busy: 0,1,2,0,1,2.
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++)
                expect_req(c, 1'b0, 32'h400 + 32'(c) * 32'h40 + 32'(k) * 32'h4, 0, 3);
        fork
            for (int k = 0; k < 2; k++) send(0, 1'b0, 32'h400 + 32'(k) * 32'h4, 0);
            for (int k = 0; k < 2; k++) send(1, 1'b0, 32'h440 + 32'(k) * 32'h4, 0);
            for (int k = 0; k < 2; k++) send(2, 1'b0, 32'h480 + 32'(k) * 32'h4, 0);
        join
        drain(200);

        expect_req(1, 1'b0, 32'h100, 0, 3);
        send(1, 1'b0, 32'h100, 0);
        drain(50);

        // Faults detected at acceptance never reach memory.
        mreq_cycles = 0;
        expect_req(2, 1'b1, 32'h102, 32'h11223344, 1);   send(2, 1'b1, 32'h102, 32'h11223344);
        expect_req(0, 1'b0, 32'h10000, 0, 1);            send(0, 1'b0, 32'h10000, 0);
        expect_req(1, 1'b0, 32'h10000, 0, 1);            send(1, 1'b0, 32'h10000, 0);
        expect_req(1, 1'b1, 32'h20000, 32'h5, 1);        send(1, 1'b1, 32'h20000, 32'h5);
        expect_req(0, 1'b0, 32'h101, 0, 1);              send(0, 1'b0, 32'h101, 0);
        expect_req(1, 1'b0, 32'h103, 0, 1);              send(1, 1'b0, 32'h103, 0);
        expect_req(0, 1'b0, 32'hFFFE, 0, 1);             send(0, 1'b0, 32'hFFFE, 0);
        drain(50);
        check("no_mem_req_on_fault", mreq_cycles, 0);

        expect_req(2, 1'b1, 32'h200, 32'hCAFEF00D, 3);   send(2, 1'b1, 32'h200, 32'hCAFEF00D);
        expect_req(0, 1'b0, 32'hFFFC, 0, 3);             send(0, 1'b0, 32'hFFFC, 0);
        drain(50);

        // Response on the last allowed cycle completes normally; one cycle later is a fault.
        rsp_delay = 63;
        expect_req(1, 1'b0, 32'h104, 0, 65);
        send(1, 1'b0, 32'h104, 0);
        drain(100);
        rsp_delay = 64;
        push(1, 1'b0, 32'h108, 0, 0, 1'b1, 4'd5, 65);
        send(1, 1'b0, 32'h108, 0);
        drain(100);
        rsp_delay = 1;

        // Memory never ready; a stray response during ISSUE must be dropped.
        ready_en = 1'b0;
        push(1, 1'b0, 32'h300, 0, 0, 1'b1, 4'd5, 65);
        send(1, 1'b0, 32'h300, 0);
        repeat (3) @(negedge CLK);
        inject = 1'b1;
        repeat (2) @(negedge CLK);
        inject = 1'b0;
        drain(100);
        push(0, 1'b1, 32'h304, 32'h77, 0, 1'b1, 4'd7, 65);
        send(0, 1'b1, 32'h304, 32'h77);
        drain(100);
        ready_en = 1'b1;

        inject = 1'b1;
        @(negedge CLK);
        inject = 1'b0;
        repeat (4) @(negedge CLK);

        // Reset while waiting on memory: transaction is abandoned silently.
        rsp_delay = 10;
        send(2, 1'b0, 32'h500, 0);
        repeat (2) @(negedge CLK);
        req_valid[1] = 1'b1;
        #3 RESET = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_mem_req_valid", mem_req_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_mem_addr", mem_addr, 0);
        req_valid = '0;
        @(negedge CLK);
        #3 RESET = 1'b1;
        rsp_delay = 1;
        repeat (15) @(negedge CLK);

        push(0, 1'b0, 32'h600, 0, mem_fn(32'h600), 1'b0, 4'd0, 3);
        push(1, 1'b0, 32'h640, 0, mem_fn(32'h640), 1'b0, 4'd0, 3);
        fork
            send(0, 1'b0, 32'h600, 0);
            send(1, 1'b0, 32'h640, 0);
        join
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of requester channels (2..8); channel 0 is the instruction-fetch channel.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter MEM_BYTES, default 65536, size of the legal address range.
REQ-005 SHALL have parameter TIMEOUT, default 64, maximum cycles for one transaction to complete.
REQ-006 SHALL have ports CLK in 1 (the only clock) and RESET in 1 (asynchronous, active-low reset).
REQ-007 SHALL have ports req_valid in NUM_CH, req_ready out NUM_CH, req_we in NUM_CH, req_addr in NUM_CH*ADDR_W, req_wdata in NUM_CH*DATA_W (channel i in slice i).
REQ-008 SHALL have ports rsp_valid out NUM_CH (one-hot pulse), rsp_data out DATA_W, rsp_exc_valid out 1, rsp_exc_code out 4.
REQ-009 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rsp_valid in 1, mem_rsp_data in DATA_W.

Function
REQ-010 SHALL keep exactly one transaction outstanding, using FSM states IDLE, ISSUE, WAIT, RESP.
REQ-011 IDLE: if any req_valid, SHALL select winner g round-robin, starting at (last_grant+1) mod NUM_CH, and assert req_ready[g] combinationally for that one cycle only.
REQ-012 On acceptance, SHALL capture addr, wdata, we and g, and update last_grant to g.
REQ-013 req_ready SHALL be 0 for every channel in all states other than IDLE.
REQ-014 SHALL flag misaligned when addr[1:0] != 0; code = 6 if we, else 0 if g==0, else 4.
REQ-015 SHALL flag access fault when addr >= MEM_BYTES (aligned only); code = 7 if we, else 1 if g==0, else 5.
REQ-016 On either flag, SHALL go IDLE->RESP and issue no memory request.
REQ-017 With no flag, SHALL go IDLE->ISSUE.
REQ-018 ISSUE: SHALL hold mem_req_valid=1 with stable mem_we/mem_addr/mem_wdata until mem_req_ready=1, then go to WAIT.
REQ-019 SHALL ignore mem_rsp_valid in ISSUE and in IDLE (stray responses are dropped).
REQ-020 WAIT: on mem_rsp_valid, SHALL capture mem_rsp_data (loads) or 0 (stores) and go to RESP.
REQ-021 SHALL run a cycle counter, cleared on acceptance and incremented each cycle in ISSUE/WAIT, width clog2(TIMEOUT+1).
REQ-022 When the counter reaches TIMEOUT with no completion, SHALL drop mem_req_valid and go to RESP with access-fault code per REQ-015.
REQ-023 If mem_rsp_valid arrives in the same cycle the counter reaches TIMEOUT, SHALL treat the transaction as completed normally (no exception).
REQ-024 RESP: SHALL assert rsp_valid[g] for exactly one cycle with rsp_data/rsp_exc_valid/rsp_exc_code, then return to IDLE; there is no back-pressure.
REQ-025 rsp_data SHALL be 0 whenever rsp_exc_valid=1.
REQ-026 Minimum load latency SHALL be 3 cycles, acceptance to rsp_valid (ISSUE ready, WAIT rsp, RESP); exception-at-accept latency SHALL be 1 cycle.
REQ-027 Requests deasserted before acceptance SHALL never be served; a requester SHALL hold req_valid and payload until req_ready.

Reset
REQ-028 RESET low SHALL asynchronously force state=IDLE, last_grant=NUM_CH-1, counter=0.
REQ-029 RESET low SHALL force all outputs to 0: req_ready, rsp_valid, rsp_data, rsp_exc_valid, rsp_exc_code, mem_req_valid, mem_we, mem_addr, mem_wdata.
REQ-030 Reset mid-transaction SHALL abandon it with no rsp_valid; any subsequent mem_rsp_valid in IDLE is ignored.

Verification
REQ-031 Ch1 load 0x100, mem ready immediately, rsp 1 cycle later with 0xDEADBEEF -> rsp_valid=3'b010 3 cycles after accept, rsp_data=0xDEADBEEF, exc 0.
REQ-032 All 3 channels request continuously after reset -> grants 0,1,2,0,1,2; no channel is granted twice before the others.
REQ-033 Ch2 store to 0x102 -> rsp_valid[2] 1 cycle after accept, exc_code 6, mem_req_valid never asserted; ch0 fetch at 0x10000 -> exc_code 1.
REQ-034 mem_req_ready held 0 -> mem_req_valid stays high with a stable address, then at TIMEOUT=64 rsp with exc_code 5 (load); a late mem_rsp_valid is ignored.
REQ-035 RESET pulsed low during WAIT -> all outputs 0 immediately, no rsp_valid; the next request after release is served normally starting at ch0.
